// File: rtl/cnn_frame_sequencer.sv
// Frame-level sequencer for the CNN lane-detection pipeline: pixel gating, FE/FC launch, timeouts, result handshake.
// Build macro CNN_SEQ_PERF_EN adds a cycle counter from EXTRACT entry to OUT entry on perf_cycles.
module cnn_frame_sequencer #(
   parameter int PIXELS_PER_FRAME   = 1024,
   parameter int FEATURES_PER_FRAME = 225,
   parameter int RESULT_W           = 48,
   parameter int TIMER_W            = 20,
   parameter int FEAT_TO            = 50000,
   parameter int BUF_TO             = 10000,
   parameter int FC_TO              = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                pixel_valid,
   output logic                pixel_ready,
   output logic                fe_start,
   input  logic                fe_done,
   input  logic                feat_valid,
   input  logic                buf_full,
   output logic                fc_start,
   input  logic                fc_valid,
   input  logic [RESULT_W-1:0] fc_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RESULT_W-1:0] res_data,
   output logic                res_timeout,
   output logic [2:0]          err_code,
   output logic                busy,
   output logic [15:0]         frame_count,
   output logic [31:0]         perf_cycles,
   output logic [2:0]          state_dbg
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXTRACT  = 3'd1,
      S_WAIT_BUF = 3'd2,
      S_FC       = 3'd3,
      S_OUT      = 3'd4
   } state_t;

   localparam int PIX_W  = $clog2(PIXELS_PER_FRAME + 1);
   localparam int FEAT_W = $clog2(FEATURES_PER_FRAME + 1);
   localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(PIXELS_PER_FRAME);
   localparam logic [FEAT_W-1:0]  FEAT_LAST = FEAT_W'(FEATURES_PER_FRAME);
   localparam logic [TIMER_W-1:0] FEAT_LIM  = TIMER_W'(FEAT_TO - 1);
   localparam logic [TIMER_W-1:0] BUF_LIM   = TIMER_W'(BUF_TO - 1);
   localparam logic [TIMER_W-1:0] FC_LIM    = TIMER_W'(FC_TO - 1);

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [PIX_W-1:0]   pix_cnt;
   logic [FEAT_W-1:0]  feat_cnt;
   logic               pending;
   logic               res_fire;
   logic               go_extract;
   logic               enter_out;

   // Handshakes: a pixel transfers on a cycle with pixel_valid && pixel_ready; a result transfers on
   // res_valid && res_ready, and res_valid/res_data/res_timeout/err_code hold steady until that cycle.
   assign pixel_ready = (state == S_EXTRACT) && (pix_cnt < PIX_LAST);
   assign res_fire    = res_valid && res_ready;
   assign busy        = (state != S_IDLE);
   assign state_dbg   = state;
   assign go_extract  = !abort && (((state == S_IDLE) && start) ||
                                   ((state == S_OUT) && res_ready && (pending || start)));
   assign enter_out   = !abort && (state == S_FC) && (fc_valid || (timer == FC_LIM));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         pix_cnt     <= '0;
         feat_cnt    <= '0;
         pending     <= 1'b0;
         fe_start    <= 1'b0;
         fc_start    <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_timeout <= 1'b0;
         err_code    <= '0;
         frame_count <= '0;
      end else begin
         fe_start <= 1'b0;
         fc_start <= 1'b0;
         timer    <= timer + 1'b1;
         if (res_fire) frame_count <= frame_count + 16'd1;
         if (abort) begin
            state       <= S_IDLE;
            timer       <= '0;
            pix_cnt     <= '0;
            feat_cnt    <= '0;
            pending     <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            err_code    <= '0;
         end else begin
            if (start && busy) pending <= 1'b1;
            if (pixel_valid && pixel_ready) pix_cnt <= pix_cnt + 1'b1;
            if (feat_valid && ((state == S_EXTRACT) || (state == S_WAIT_BUF)) && (feat_cnt != FEAT_LAST))
               feat_cnt <= feat_cnt + 1'b1;
            case (state)
               S_EXTRACT: begin
                  if ((pix_cnt == PIX_LAST) && fe_done) begin
                     state <= S_WAIT_BUF;
                     timer <= '0;
                  end else if (timer == FEAT_LIM) begin
                     state       <= S_WAIT_BUF;
                     timer       <= '0;
                     err_code[0] <= 1'b1;
                  end
               end
               S_WAIT_BUF: begin
                  if (buf_full || (feat_cnt == FEAT_LAST) || (timer == BUF_LIM)) begin
                     state    <= S_FC;
                     timer    <= '0;
                     fc_start <= 1'b1;
                     if (!(buf_full || (feat_cnt == FEAT_LAST))) err_code[1] <= 1'b1;
                  end
               end
               S_FC: begin
                  // A result arriving in the timeout cycle is still a real result.
                  if (fc_valid) begin
                     res_data <= fc_data;
                  end else if (timer == FC_LIM) begin
                     res_data    <= RESULT_W'(pix_cnt);
                     res_timeout <= 1'b1;
                     err_code[2] <= 1'b1;
                  end
                  if (enter_out) begin
                     state     <= S_OUT;
                     timer     <= '0;
                     res_valid <= 1'b1;
                  end
               end
               S_OUT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     pending   <= pending && start;
                     if (!go_extract) begin
                        state <= S_IDLE;
                        timer <= '0;
                     end
                  end
               end
               default: ;
            endcase
            if (go_extract) begin
               state       <= S_EXTRACT;
               timer       <= '0;
               fe_start    <= 1'b1;
               pix_cnt     <= '0;
               feat_cnt    <= '0;
               err_code    <= '0;
               res_timeout <= 1'b0;
            end
         end
      end
   end

`ifdef CNN_SEQ_PERF_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         perf_cnt    <= '0;
         perf_cycles <= '0;
      end else begin
         if (go_extract) perf_cnt <= '0;
         else if (perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
         if (enter_out) perf_cycles <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
      end
   end
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomised frame-level bench for cnn_frame_sequencer, scored against an outcome model of each frame.
module tb_cnn_frame_sequencer;
   localparam int PIX  = 16;
   localparam int FEAT = 4;
   localparam int TO   = 64;
   localparam int RW   = 48;
   localparam int EW   = RW + 4;

   logic          clk = 1'b0;
   logic          rst, start, abort, pixel_valid, fe_done, feat_valid, buf_full, fc_valid, res_ready;
   logic [RW-1:0] fc_data;
   logic          pixel_ready, fe_start, fc_start, res_valid, res_timeout, busy;
   logic [RW-1:0] res_data;
   logic [2:0]    err_code, state_dbg;
   logic [15:0]   frame_count;
   logic [31:0]   perf_cycles;

   int n_tests = 0, n_fail = 0;
   int frames_done = 0, fe_exp = 0, fc_exp = 0;
   int pix_acc = 0, fe_cnt = 0, fc_cnt = 0;
   bit queued = 1'b0;
   logic [EW-1:0] exp_q[$];

   always #5 clk = ~clk;

   cnn_frame_sequencer #(
      .PIXELS_PER_FRAME(PIX), .FEATURES_PER_FRAME(FEAT), .RESULT_W(RW), .TIMER_W(20),
      .FEAT_TO(TO), .BUF_TO(TO), .FC_TO(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .fe_start(fe_start),
      .fe_done(fe_done), .feat_valid(feat_valid), .buf_full(buf_full), .fc_start(fc_start),
      .fc_valid(fc_valid), .fc_data(fc_data), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_timeout(res_timeout), .err_code(err_code), .busy(busy),
      .frame_count(frame_count), .perf_cycles(perf_cycles), .state_dbg(state_dbg)
   );

   // Event counters sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (pixel_valid && pixel_ready) pix_acc <= pix_acc + 1;
         if (fe_start) fe_cnt <= fe_cnt + 1;
         if (fc_start) fc_cnt <= fc_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      start = 0; abort = 0; pixel_valid = 0; fe_done = 0; feat_valid = 0;
      fc_valid = 0; fc_data = '0; res_ready = 0;
   endtask

   task automatic run_frame(input int sent, input bit fe_ok, input int n_feat, input bit use_buf,
                            input bit fc_resp, input int fc_k, input logic [RW-1:0] data,
                            input int bp, input int queue_n, input bit abort_xfer);
      int            n, pix_base, acc;
      logic [2:0]    exp_err;
      logic [RW-1:0] exp_data;
      logic [EW-1:0] exp;
      acc        = (sent < PIX) ? sent : PIX;
      exp_err[0] = !(sent >= PIX && fe_ok);
      exp_err[1] = !(n_feat >= FEAT || use_buf);
      exp_err[2] = !fc_resp;
      exp_data   = fc_resp ? data : RW'(acc);
      exp_q.push_back({1'b0, !fc_resp, exp_err, exp_data});

      buf_full = use_buf;
      if (!queued) begin
         start = 1; tick(); start = 0;
      end
      queued = 1'b0;
      n = 0;
      while (!fe_start && n < 300) begin tick(); n++; end
      check("fe_start_seen", fe_start, 1);
      pix_base = pix_acc;

      for (int i = 0; i < sent; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            pixel_valid = 0; feat_valid = 0; fe_done = 0; fc_valid = 0;
            tick();
         end
         pixel_valid = 1;
         feat_valid  = (i < n_feat);
         fe_done     = (i == 0);
         fc_valid    = (i == 1);
         fc_data     = RW'($urandom);
         tick();
      end
      pixel_valid = 0; feat_valid = 0; fe_done = 0; fc_valid = 0;
      if (fe_ok) begin
         fe_done = 1; tick(); fe_done = 0;
      end

      n = 0;
      while (!fc_start && n < 300) begin tick(); n++; end
      check("fc_start_seen", fc_start, 1);
      for (int i = 0; i < TO; i++) begin
         start    = (queue_n >= 1 && i == 0) || (queue_n >= 2 && i == 1);
         fc_valid = fc_resp && (i == fc_k);
         fc_data  = data;
         tick();
         if (fc_resp && i == fc_k) break;
      end
      start = 0; fc_valid = 0;

      n = 0;
      while (!res_valid && n < 20) begin tick(); n++; end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("res_valid", res_valid, 1);
      check("res_data", res_data, exp[RW-1:0]);
      check("res_timeout", res_timeout, exp[RW+3]);
      check("err_code", err_code, exp[RW+2:RW]);
      check("out_pixel_ready", pixel_ready, 0);
      for (int i = 0; i < bp; i++) begin
         res_ready = 0; pixel_valid = 1;
         tick();
         check("bp_valid", res_valid, 1);
         check("bp_data", res_data, exp[RW-1:0]);
      end
      pixel_valid = 0;

      res_ready = 1; abort = abort_xfer;
      tick();
      res_ready = 0; abort = 0;
      frames_done++; fe_exp++; fc_exp++;
      check("frame_count", frame_count, 16'(frames_done));
      check("res_valid_drop", res_valid, 0);
      check("pix_accepted", pix_acc - pix_base, acc);
      check("fe_start_pulses", fe_cnt, fe_exp);
      check("fc_start_pulses", fc_cnt, fc_exp);
      queued = (queue_n > 0) && !abort_xfer;
      if (queued) begin
         check("queued_state", state_dbg, 3'd1);
         check("queued_fe_start", fe_start, 1);
      end else begin
         check("idle_busy", busy, 0);
      end
      if (abort_xfer) begin
         check("abort_xfer_data", res_data, 0);
         check("abort_xfer_err", err_code, 0);
      end
   endtask

   initial begin
      int            seen;
      logic [63:0]   r64;
      rst = 1; buf_full = 0;
      clear_inputs();
      repeat (3) tick();
      check("rst_pixel_ready", pixel_ready, 0);
      check("rst_fe_start", fe_start, 0);
      check("rst_fc_start", fc_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_timeout", res_timeout, 0);
      check("rst_err_code", err_code, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_perf", perf_cycles, 0);
      check("rst_state", state_dbg, 0);
      rst = 0;
      tick();

      // nominal, FC timeout, extract+buffer timeout, queued pair, late FC result
      run_frame(16, 1, 4, 0, 1, 3, RW'(-5), 10, 0, 0);
`ifdef CNN_SEQ_PERF_EN
      check("perf_nonzero", perf_cycles != 0, 1);
`else
      check("perf_tied", perf_cycles, 0);
`endif
      run_frame(16, 1, 4, 0, 0, 0, '0, 2, 0, 0);
      run_frame(10, 1, 0, 0, 1, 5, RW'(48'h1234_5678_9abc), 1, 0, 0);
      run_frame(16, 1, 4, 1, 1, 2, RW'(48'h0000_0000_00aa), 1, 2, 0);
      run_frame(20, 1, 5, 0, 1, 63, RW'(48'h8000_0000_0001), 0, 0, 0);
      run_frame(16, 1, 4, 0, 1, 4, RW'(48'h7), 0, 1, 1);

      for (int f = 0; f < 20; f++) begin
         r64 = {$urandom(), $urandom()};
         run_frame($urandom_range(10, 20), $urandom_range(0, 3) != 0, $urandom_range(0, 6),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(55, 63),
                   r64[RW-1:0], $urandom_range(0, 4),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   $urandom_range(0, 7) == 0);
      end
      while (queued) run_frame(16, 1, 4, 0, 1, 1, RW'(48'h55), 0, 0, 0);

      // abort while waiting on the flatten buffer, with a start already queued
      buf_full = 0;
      start = 1; tick(); start = 0;
      check("abort_fe_start", fe_start, 1);
      for (int i = 0; i < PIX; i++) begin pixel_valid = 1; tick(); end
      pixel_valid = 0;
      fe_done = 1; tick(); fe_done = 0;
      repeat (3) tick();
      start = 1; tick(); start = 0;
      check("abort_in_wait_buf", state_dbg, 3'd2);
      abort = 1; tick(); abort = 0;
      fe_exp++;
      check("abort_busy", busy, 0);
      check("abort_state", state_dbg, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_err", err_code, 0);
      check("abort_frame_count", frame_count, 16'(frames_done));
      seen = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (busy || res_valid) seen++;
      end
      check("abort_stays_idle", seen, 0);
      check("abort_fe_pulses", fe_cnt, fe_exp);

      // reset mid-frame also clears frame_count
      start = 1; tick(); start = 0;
      for (int i = 0; i < 5; i++) begin pixel_valid = 1; tick(); end
      pixel_valid = 0;
      rst = 1; tick(); rst = 0;
      check("midrst_frame_count", frame_count, 0);
      check("midrst_busy", busy, 0);
      check("midrst_pixel_ready", pixel_ready, 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
